// File: rtl/setup_host_pkg.sv
// Shared lock package: PIN and setup packet types, master PIN, default
// configuration and the sanitisation helpers used at commit time.
package setup_host_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        pinPac_t    pin1;
        pinPac_t    pin2;
        pinPac_t    pin3;
        pinPac_t    pin4;
    } setupPac_t;

    localparam logic [6:0] TIME_MIN = 7'd5;
    localparam logic [6:0] TIME_MAX = 7'd60;

    localparam pinPac_t MASTER_PIN = '{status: 1'b1, digit1: 4'd1, digit2: 4'd2,
                                       digit3: 4'd3, digit4: 4'd4};

    localparam pinPac_t PIN_BLANK = '{status: 1'b0, digit1: 4'd0, digit2: 4'd0,
                                      digit3: 4'd0, digit4: 4'd0};

    localparam setupPac_t CFG_DEFAULT = '{
        bip_status:      1'b1,
        bip_time:        7'd10,
        tranca_aut_time: 7'd10,
        pin1:            '{status: 1'b1, digit1: 4'd1, digit2: 4'd2, digit3: 4'd3, digit4: 4'd4},
        pin2:            PIN_BLANK,
        pin3:            PIN_BLANK,
        pin4:            PIN_BLANK
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_REQ,
        ST_CAPTURE,
        ST_RELEASE,
        ST_LOCKOUT
    } host_state_t;

    function automatic logic pin_digits_valid(input pinPac_t p);
        return (p.digit1 <= 4'd9) && (p.digit2 <= 4'd9) &&
               (p.digit3 <= 4'd9) && (p.digit4 <= 4'd9);
    endfunction

    function automatic logic [6:0] clamp_time(input logic [6:0] t);
        if (t < TIME_MIN) return TIME_MIN;
        if (t > TIME_MAX) return TIME_MAX;
        return t;
    endfunction

endpackage

// File: rtl/setup_host_cfg_sanitize.sv
// Combinational clean-up of a proposed configuration: clamps the times and
// invalidates (or, for pin1, rejects) PIN slots holding non-decimal digits.
module cfg_sanitize
    import setup_host_pkg::*;
(
    input  setupPac_t cfg_in,
    input  pinPac_t   prev_pin1,
    output setupPac_t cfg_out
);

    always_comb begin
        cfg_out                 = cfg_in;
        cfg_out.bip_time        = clamp_time(cfg_in.bip_time);
        cfg_out.tranca_aut_time = clamp_time(cfg_in.tranca_aut_time);

        // pin1 is the user's only guaranteed way in, so a bad one is dropped
        // entirely rather than disabled.
        if (!pin_digits_valid(cfg_in.pin1)) begin
            cfg_out.pin1 = prev_pin1;
        end
        cfg_out.pin1.status = 1'b1;

        if (!pin_digits_valid(cfg_in.pin2)) cfg_out.pin2.status = 1'b0;
        if (!pin_digits_valid(cfg_in.pin3)) cfg_out.pin3.status = 1'b0;
        if (!pin_digits_valid(cfg_in.pin4)) cfg_out.pin4.status = 1'b0;
    end

endmodule

// File: rtl/setup_host.sv
// Host side of the lock setup handshake: master-PIN gate, setup_on request and
// sanitised commit of the new configuration. Define SETUP_HOST_LOCKOUT_EN for
// the wrong-PIN attempt counter and LOCKOUT state.
module setup_host
    import setup_host_pkg::*;
#(
    parameter int unsigned ARM_TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned LOCKOUT_CYCLES     = 1_500_000_000,
    parameter int unsigned MAX_ATTEMPTS       = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      setup_req,
    input  pinPac_t   pin_in,
    input  logic      setup_end,
    input  setupPac_t data_setup_new,
    output logic      setup_on,
    output setupPac_t data_setup_old,
    output logic      in_setup,
    output logic      pin_fail,
    output logic      cfg_updated,
    output logic      lockout
);

    localparam int unsigned ARM_W = (ARM_TIMEOUT_CYCLES > 1) ? $clog2(ARM_TIMEOUT_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT_CYCLES - 1);

    host_state_t      state;
    logic [ARM_W-1:0] arm_cnt;
    logic             pin_ok;
    setupPac_t        cfg_clean;

    assign pin_ok = (pin_in.digit4 == MASTER_PIN.digit1) &&
                    (pin_in.digit3 == MASTER_PIN.digit2) &&
                    (pin_in.digit2 == MASTER_PIN.digit3) &&
                    (pin_in.digit1 == MASTER_PIN.digit4);

    cfg_sanitize u_sanitize (
        .cfg_in    (data_setup_new),
        .prev_pin1 (data_setup_old.pin1),
        .cfg_out   (cfg_clean)
    );

`ifdef SETUP_HOST_LOCKOUT_EN
    localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [ATT_W-1:0]  ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [ATT_W-1:0]  att_cnt;
    logic [ATT_W-1:0]  att_next;
    logic [LOCK_W-1:0] lock_cnt;

    assign att_next = (att_cnt == ATT_MAX) ? att_cnt : att_cnt + ATT_W'(1);
`else
    logic unused_lock_params;
    assign unused_lock_params = ^{LOCKOUT_CYCLES, MAX_ATTEMPTS};
    assign lockout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            arm_cnt        <= '0;
            setup_on       <= 1'b0;
            in_setup       <= 1'b0;
            pin_fail       <= 1'b0;
            cfg_updated    <= 1'b0;
            data_setup_old <= CFG_DEFAULT;
`ifdef SETUP_HOST_LOCKOUT_EN
            att_cnt        <= '0;
            lock_cnt       <= '0;
            lockout        <= 1'b0;
`endif
        end else begin
            pin_fail    <= 1'b0;
            cfg_updated <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (setup_req) begin
                        state   <= ST_ARMED;
                        arm_cnt <= '0;
                    end
                end
                // A PIN arriving on the timeout cycle takes priority.
                ST_ARMED: begin
                    if (pin_in.status) begin
                        if (pin_ok) begin
`ifdef SETUP_HOST_LOCKOUT_EN
                            att_cnt <= '0;
`endif
                            state    <= ST_REQ;
                            setup_on <= 1'b1;
                            in_setup <= 1'b1;
                        end else begin
                            pin_fail <= 1'b1;
`ifdef SETUP_HOST_LOCKOUT_EN
                            att_cnt <= att_next;
                            if (att_next == ATT_MAX) begin
                                state    <= ST_LOCKOUT;
                                lockout  <= 1'b1;
                                lock_cnt <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
`else
                            state <= ST_IDLE;
`endif
                        end
                    end else if (arm_cnt == ARM_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end
                end
                ST_REQ: begin
                    if (!setup_end) begin
                        data_setup_old <= cfg_clean;
                        cfg_updated    <= 1'b1;
                        setup_on       <= 1'b0;
                        state          <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (setup_end) begin
                        state    <= ST_IDLE;
                        in_setup <= 1'b0;
                    end
                end
`ifdef SETUP_HOST_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state   <= ST_IDLE;
                        lockout <= 1'b0;
                        att_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    setup_on <= 1'b0;
                    in_setup <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_setup_host.sv
// Self-checking bench for setup_host: cycle model with deadline timers plus
// directed literal checks of handshake, clamping, lockout and timeout.
`timescale 1ns/1ps
module tb_setup_host;
    import setup_host_pkg::*;

    localparam int unsigned ARM_T   = 20;
    localparam int unsigned LOCK_T  = 30;
    localparam int unsigned MAX_ATT = 3;
`ifdef SETUP_HOST_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      setup_req = 1'b0;
    logic      setup_end = 1'b1;
    pinPac_t   pin_in = '0;
    setupPac_t data_setup_new = '0;
    logic      setup_on, in_setup, pin_fail, cfg_updated, lockout;
    setupPac_t data_setup_old;

    setup_host #(
        .ARM_TIMEOUT_CYCLES (ARM_T),
        .LOCKOUT_CYCLES     (LOCK_T),
        .MAX_ATTEMPTS       (MAX_ATT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .setup_req      (setup_req),
        .pin_in         (pin_in),
        .setup_end      (setup_end),
        .data_setup_new (data_setup_new),
        .setup_on       (setup_on),
        .data_setup_old (data_setup_old),
        .in_setup       (in_setup),
        .pin_fail       (pin_fail),
        .cfg_updated    (cfg_updated),
        .lockout        (lockout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pinPac_t mk_pin(input logic s, input logic [3:0] d1, d2, d3, d4);
        pinPac_t p;
        p.status = s; p.digit1 = d1; p.digit2 = d2; p.digit3 = d3; p.digit4 = d4;
        return p;
    endfunction

    function automatic setupPac_t tb_default();
        setupPac_t c;
        c = '0;
        c.bip_status      = 1'b1;
        c.bip_time        = 7'd10;
        c.tranca_aut_time = 7'd10;
        c.pin1            = mk_pin(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        return c;
    endfunction

    function automatic bit digits_ok(input pinPac_t p);
        logic [3:0] d [4];
        d = '{p.digit1, p.digit2, p.digit3, p.digit4};
        foreach (d[i]) if (d[i] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int clamp_int(input int v);
        return (v < 5) ? 5 : ((v > 60) ? 60 : v);
    endfunction

    function automatic setupPac_t expect_commit(input setupPac_t n, input pinPac_t keep1);
        setupPac_t r;
        pinPac_t   pins [4];
        r = n;
        r.bip_time        = 7'(clamp_int(int'(n.bip_time)));
        r.tranca_aut_time = 7'(clamp_int(int'(n.tranca_aut_time)));
        pins = '{n.pin1, n.pin2, n.pin3, n.pin4};
        foreach (pins[i]) if (!digits_ok(pins[i])) pins[i].status = 1'b0;
        if (!digits_ok(n.pin1)) pins[0] = keep1;
        pins[0].status = 1'b1;
        r.pin1 = pins[0]; r.pin2 = pins[1]; r.pin3 = pins[2]; r.pin4 = pins[3];
        return r;
    endfunction

    // Behavioural model: phase plus absolute-cycle deadlines.
    localparam int P_IDLE = 0, P_ARMED = 1, P_OFFER = 2, P_CAPT = 3, P_DRAIN = 4, P_LOCKED = 5;
    int        cyc = 0, phase = P_IDLE, fails = 0, arm_until = 0, lock_until = 0;
    setupPac_t m_cfg;
    logic      m_pf = 1'b0, m_cu = 1'b0;
    int        pf_seen = 0, lock_seen = 0, on_seen = 0;

    task automatic model_step();
        cyc++;
        m_pf = 1'b0;
        m_cu = 1'b0;
        if (rst) begin
            phase = P_IDLE;
            fails = 0;
            m_cfg = tb_default();
        end else begin
            case (phase)
                P_IDLE: if (setup_req) begin
                    phase = P_ARMED;
                    arm_until = cyc + ARM_T;
                end
                P_ARMED: begin
                    if (pin_in.status) begin
                        if (pin_in.digit4 == 4'd1 && pin_in.digit3 == 4'd2 &&
                            pin_in.digit2 == 4'd3 && pin_in.digit1 == 4'd4) begin
                            fails = 0;
                            phase = P_OFFER;
                        end else begin
                            m_pf = 1'b1;
                            fails++;
                            if (LOCK_EN && fails >= MAX_ATT) begin
                                phase = P_LOCKED;
                                lock_until = cyc + LOCK_T;
                            end else begin
                                phase = P_IDLE;
                            end
                        end
                    end else if (cyc == arm_until) begin
                        phase = P_IDLE;
                    end
                end
                P_OFFER: if (!setup_end) begin
                    m_cfg = expect_commit(data_setup_new, m_cfg.pin1);
                    m_cu  = 1'b1;
                    phase = P_CAPT;
                end
                P_CAPT:  phase = P_DRAIN;
                P_DRAIN: if (setup_end) phase = P_IDLE;
                P_LOCKED: if (cyc == lock_until) begin
                    phase = P_IDLE;
                    fails = 0;
                end
                default: phase = P_IDLE;
            endcase
        end
    endtask

    always begin
        @(posedge clk);
        model_step();
        #2;
        check("setup_on",       setup_on,       phase == P_OFFER);
        check("in_setup",       in_setup,       phase == P_OFFER || phase == P_CAPT || phase == P_DRAIN);
        check("lockout",        lockout,        phase == P_LOCKED);
        check("pin_fail",       pin_fail,       m_pf);
        check("cfg_updated",    cfg_updated,    m_cu);
        check("data_setup_old", data_setup_old, m_cfg);
        if (pin_fail) pf_seen++;
        if (lockout)  lock_seen++;
        if (setup_on) on_seen++;
    end

    task automatic req();
        setup_req = 1'b1;
        @(negedge clk);
        setup_req = 1'b0;
    endtask

    task automatic key(input logic [3:0] a, b, c, d);
        pin_in.digit4 = a; pin_in.digit3 = b; pin_in.digit2 = c; pin_in.digit1 = d;
        pin_in.status = 1'b1;
        @(negedge clk);
        pin_in.status = 1'b0;
    endtask

    task automatic commit(input setupPac_t n);
        data_setup_new = n;
        setup_end = 1'b0;
        @(negedge clk);
        setup_end = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((in_setup || lockout) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {in_setup, lockout}, 2'b00);
    endtask

    task automatic full_session(input setupPac_t n);
        req();
        key(4'd1, 4'd2, 4'd3, 4'd4);
        check("session_on", setup_on, 1'b1);
        commit(n);
        wait_idle("session_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        setupPac_t n;
        int pf0, lk0, on0;

        repeat (3) @(negedge clk);
        check("rst_cfg",      data_setup_old, tb_default());
        check("rst_pin1_d1",  data_setup_old.pin1.digit1, 4'd1);
        check("rst_bip_time", data_setup_old.bip_time, 7'd10);
        check("rst_setup_on", setup_on, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Successful setup; pin1 with status 0 is forced on, 60 is in range.
        req();
        key(4'd1, 4'd2, 4'd3, 4'd4);
        check("ok_setup_on_next", setup_on, 1'b1);
        n = tb_default();
        n.bip_time = 7'd30;
        n.tranca_aut_time = 7'd60;
        n.pin1 = mk_pin(1'b0, 4'd4, 4'd3, 4'd2, 4'd1);
        commit(n);
        check("ok_cfg_updated", cfg_updated, 1'b1);
        check("ok_bip_time",    data_setup_old.bip_time, 7'd30);
        check("ok_tranca",      data_setup_old.tranca_aut_time, 7'd60);
        check("ok_pin1",        data_setup_old.pin1, mk_pin(1'b1, 4'd4, 4'd3, 4'd2, 4'd1));
        check("ok_setup_on_off", setup_on, 1'b0);
        wait_idle("ok_idle");

        // Clamp and PIN validity, with some idle cycles in REQ first.
        req();
        key(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        n = tb_default();
        n.bip_time = 7'd2;
        n.tranca_aut_time = 7'd99;
        n.pin1 = mk_pin(1'b1, 4'hB, 4'd1, 4'd1, 4'd1);
        n.pin2 = mk_pin(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
        n.pin3 = mk_pin(1'b1, 4'd1, 4'hB, 4'd2, 4'd3);
        n.pin4 = mk_pin(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
        commit(n);
        check("clamp_bip_lo",    data_setup_old.bip_time, 7'd5);
        check("clamp_tranca_hi", data_setup_old.tranca_aut_time, 7'd60);
        check("pin3_status",     data_setup_old.pin3.status, 1'b0);
        check("pin3_digits",     data_setup_old.pin3.digit2, 4'hB);
        check("pin1_retained",   data_setup_old.pin1, mk_pin(1'b1, 4'd4, 4'd3, 4'd2, 4'd1));
        check("pin2_valid",      data_setup_old.pin2.status, 1'b1);
        check("pin4_nines",      data_setup_old.pin4.status, 1'b1);
        wait_idle("clamp_idle");

        // Three wrong master PINs.
        pf0 = pf_seen;
        lk0 = lock_seen;
        repeat (3) begin
            req();
            key(4'd9, 4'd9, 4'd9, 4'd9);
            @(negedge clk);
        end
        check("wrong_pin_fail_count", pf_seen - pf0, 3);
        check("wrong_lockout", lockout, LOCK_EN);
        req();
        key(4'd1, 4'd2, 4'd3, 4'd4);
        check("lockout_req_ignored", setup_on, !LOCK_EN);
        n = tb_default();
        n.bip_time = 7'd40;
        commit(n);
        check("lockout_no_commit", cfg_updated, !LOCK_EN);
        wait_idle("lockout_end");
        check("lockout_len", lock_seen - lk0, LOCK_EN ? LOCK_T : 0);
        n.bip_time = 7'd20;
        full_session(n);

        // A match clears the attempt count.
        repeat (2) begin req(); key(4'd9, 4'd9, 4'd9, 4'd9); @(negedge clk); end
        full_session(n);
        repeat (2) begin req(); key(4'd1, 4'd1, 4'd1, 4'd1); @(negedge clk); end
        check("count_cleared", lockout, 1'b0);

        // Arm timeout: PIN on the last armed cycle wins, one later is ignored.
        req();
        repeat (ARM_T - 1) @(negedge clk);
        key(4'd1, 4'd2, 4'd3, 4'd4);
        check("timeout_edge_pin", setup_on, 1'b1);
        commit(n);
        wait_idle("timeout_edge_idle");
        req();
        repeat (ARM_T) @(negedge clk);
        on0 = on_seen;
        key(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        check("timeout_no_setup_on", on_seen - on0, 0);
        check("timeout_in_setup", in_setup, 1'b0);

        // Reset during REQ.
        req();
        key(4'd1, 4'd2, 4'd3, 4'd4);
        check("rst_req_setup_on_pre", setup_on, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_req_setup_on", setup_on, 1'b0);
        check("rst_req_in_setup", in_setup, 1'b0);
        check("rst_req_cfg", data_setup_old, tb_default());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        full_session(n);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/setup_host.md
# setup_host

Host side of the setup handshake for the digital lock. Owns the live configuration register (`setupPac_t`) and presents it to the setup FSM as `data_setup_old`. Gates entry into setup mode behind the master PIN and drives `setup_on`. Captures, sanitises and commits `data_setup_new` when the setup FSM signals completion on `setup_end`.

## Interface
- `ARM_TIMEOUT_CYCLES`, default 500_000_000: cycles ARMED waits for a PIN before returning to IDLE (10 s at 50 MHz).
- `LOCKOUT_CYCLES`, default 1_500_000_000: LOCKOUT duration.
- `MAX_ATTEMPTS`, default 3: consecutive wrong master PINs that trigger LOCKOUT.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `setup_req` input 1: one-cycle pulse requesting setup mode.
- `pin_in` input `pinPac_t`: PIN assembler output. `status` pulses on confirm. `digit4` holds the first key typed, `digit1` the last.
- `setup_end` input 1: from the setup FSM. Idles high; low means `data_setup_new` is valid.
- `data_setup_new` input `setupPac_t`: configuration proposed by the setup FSM.
- `setup_on` output 1: setup-mode request to the setup FSM.
- `data_setup_old` output `setupPac_t`: committed configuration.
- `in_setup` output 1: high in REQ, CAPTURE and RELEASE.
- `pin_fail` output 1: one-cycle pulse on a wrong master PIN.
- `cfg_updated` output 1: one-cycle pulse on commit.
- `lockout` output 1: high in LOCKOUT.

## Operation
- Reset values:
  - State is IDLE.
  - `setup_on`, `in_setup`, `pin_fail`, `cfg_updated` and `lockout` are 0.
  - The attempt counter and timers are 0.
  - `data_setup_old` = `CFG_DEFAULT`: `bip_status`=1, `bip_time`=10, `tranca_aut_time`=10, pin1={status 1, 1,2,3,4}, pin2..pin4={status 0, 0,0,0,0}.
- State transitions:
  - IDLE: on `setup_req` go to ARMED and clear the arm timer.
  - ARMED, on `pin_in.status`: compare `pin_in.digit4..digit1` against `MASTER_PIN.digit1..digit4`.
    - Match: clear the attempt counter and go to REQ.
    - Mismatch: pulse `pin_fail` and increment the counter. Go to LOCKOUT if the counter reaches `MAX_ATTEMPTS`, otherwise to IDLE.
  - ARMED, arm timer reaching `ARM_TIMEOUT_CYCLES`-1 with no PIN: go to IDLE. The attempt count is unchanged.
  - REQ: `setup_on`=1. On the first cycle `setup_end`==0, latch the sanitised `data_setup_new` into `data_setup_old`, pulse `cfg_updated`, go to CAPTURE.
  - CAPTURE: `setup_on`=0. Go to RELEASE.
  - RELEASE: `setup_on`=0. On `setup_end`==1 go to IDLE.
  - LOCKOUT: `lockout`=1. `setup_req` and `pin_in` are ignored. After `LOCKOUT_CYCLES` cycles, clear the counter and go to IDLE.
- Sanitisation, applied at commit:
  - `bip_time` and `tranca_aut_time` (7-bit, unsigned) are clamped to 5..60.
  - `bip_status` passes through unchanged.
  - pin1.status is forced to 1.
  - Any pinN whose digit1..digit4 contains a value >9 is committed with status 0, and its digits are kept.
  - If pin1 has an invalid digit, the previous pin1 is retained.
- `data_setup_old` changes only on the commit cycle and on reset. It is stable through REQ.
- `setup_req` in any state other than IDLE is ignored. A `pin_in.status` outside ARMED is ignored.
- A `pin_in.status` in the same cycle as the arm timeout: the PIN wins.

## Timing
- A matching PIN in cycle N gives `setup_on`=1 from cycle N+1.
- `setup_end` sampled low in cycle M:
  - `data_setup_old` and `cfg_updated` are updated at M+1.
  - `setup_on` falls at M+1.
- Exit to IDLE happens one cycle after `setup_end` is seen high in RELEASE.
- All outputs are registered. No combinational path from any input to any output.
- Reset mid-handshake returns the block to IDLE with `setup_on`=0 and `data_setup_old`=`CFG_DEFAULT`. The setup FSM shares `rst`.
- Counter widths are `$clog2` of the respective parameter. The attempt counter saturates at `MAX_ATTEMPTS`.

## Configuration
- `SETUP_HOST_LOCKOUT_EN` defined: attempt counter, LOCKOUT state and `lockout` output behave as above.
- `SETUP_HOST_LOCKOUT_EN` undefined:
  - No attempt counter and no LOCKOUT state.
  - `lockout` is tied to 0.
  - A wrong PIN pulses `pin_fail` and returns to IDLE.
  - `LOCKOUT_CYCLES` and `MAX_ATTEMPTS` are unused.

## Structure
- Shared lock package:
  - `pinPac_t` and `setupPac_t`, already defined there.
  - New constants `MASTER_PIN` (`pinPac_t`), `CFG_DEFAULT` (`setupPac_t`), `TIME_MIN`=5 and `TIME_MAX`=60.
- Sub-module `cfg_sanitize`: combinational, `setupPac_t` in plus previous pin1, `setupPac_t` out. It implements the clamp and validity rules so they are testable standalone.

## Test plan
Bench uses `ARM_TIMEOUT_CYCLES`=20, `LOCKOUT_CYCLES`=30, `MAX_ATTEMPTS`=3, with `SETUP_HOST_LOCKOUT_EN` defined.
- Reset: `data_setup_old` equals `CFG_DEFAULT` (pin1=1234, times=10), `setup_on`=0, `setup_end` idle high.
- Successful setup: `setup_req`, PIN 1234 confirm.
  - `setup_on`=1 the next cycle.
  - Drive `data_setup_new` with `bip_time`=30 and `setup_end`=0 → `cfg_updated` pulses, `data_setup_old.bip_time`=30, `setup_on` falls.
  - Raise `setup_end` → IDLE.
- Clamp at commit:
  - `bip_time`=2 and `tranca_aut_time`=99 commit as 5 and 60.
  - pin3 with digit 0xB commits with status 0.
  - pin1 with 0xB retains the old pin1.
- Wrong PIN: three requests each with PIN 9999.
  - `pin_fail` pulses three times, then `lockout`=1 for 30 cycles.
  - `setup_req` during lockout is ignored.
  - Afterwards PIN 1234 is accepted.
- Arm timeout: `setup_req` with no PIN → IDLE after 20 cycles, `setup_on` never asserted.
- Reset asserted in REQ: `setup_on`=0 immediately and config returns to `CFG_DEFAULT`.
